dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter AWIDTH, default 14: RAM word-address width; byte address is AWIDTH+2 bits.
REQ-002 Parameter DWIDTH, default 32: RAM data width; fixed at 32 (4 byte lanes).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  pipeline memory request present.
REQ-006 req_ready  output  1  unit accepts request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 byte, 1 half, 2 word; 3 reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  AWIDTH+2  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected (reserved size, or misaligned without feature).
REQ-015 mem_addr  output  AWIDTH  word address to RAM port.
REQ-016 mem_d  output  32  write data, lane-aligned.
REQ-017 mem_wen  output  1  RAM write enable.
REQ-018 mem_wbe  output  4  RAM byte enables; bit i = bits [8i+7:8i].
REQ-019 mem_q  input  32  RAM read data, valid one cycle after address.

Function
REQ-020 Accept = req_valid && req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-021 States: IDLE, LD1 (await beat-0 data), LD2 (await beat-1 data), ST2 (write high beat), RSP (present load result).
REQ-022 In IDLE, mem_addr SHALL be req_addr[AWIDTH+1:2] combinationally so the RAM samples it on the accept edge; otherwise the stored next-word address.
REQ-023 mem_wen SHALL be 1 only in the accept cycle of a store or in ST2; mem_wbe SHALL be 0 whenever mem_wen is 0.
REQ-024 Aligned store accepted cycle N: mem_wbe = size mask shifted by req_addr[1:0], mem_d = data shifted by 8*req_addr[1:0]; rsp_valid=1, rsp_err=0 at N+1; state stays IDLE.
REQ-025 Aligned load accepted cycle N: LD1 at N+1 captures mem_q, extracts lanes, extends; rsp_valid with rsp_rdata at N+2 (RSP state), then IDLE.
REQ-026 Misaligned = half at offset 3, word at offsets 1-3; spans words W and W+1, W+1 computed modulo 2^AWIDTH (top word wraps to 0).
REQ-027 Reserved size 3: no RAM write, rsp_valid=1, rsp_err=1, rsp_rdata=0 at N+1.
REQ-028 Outputs registered except mem_addr/mem_d/mem_wen/mem_wbe during IDLE accept.
REQ-029 req_* inputs are sampled only at accept; later changes SHALL not affect the operation in flight.

Reset
REQ-030 rst SHALL force IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, internal data registers 0; mem_wen=0 and mem_wbe=0 while rst is high.
REQ-031 rst during LD1/LD2/ST2/RSP SHALL abort with no response; an already-written beat-0 store byte set is not undone; ST2 write is suppressed.

Configuration
REQ-032 Macro DMEM_LSU_MISALIGN_EN defined: misaligned load issues W at N, W+1 at N+1 (LD1->LD2), merges, rsp at N+3; misaligned store writes low lanes of W at N, high lanes of W+1 in ST2 at N+1, rsp at N+2.
REQ-033 Macro undefined: misaligned request performs no RAM access, rsp_valid=1, rsp_err=1, rsp_rdata=0 at N+1; LD2 and ST2 not built.

Structure
REQ-034 Shared package dmem_pkg SHALL hold size encodings (SZ_B/SZ_H/SZ_W), FSM state encodings and the byte-mask table.
REQ-035 One sub-module dmem_lsu_align: combinational lane shift/merge and sign/zero extension, instanced for load data.

Verification
REQ-036 Store word 0xDEADBEEF @0x0010 -> N: mem_addr=4, mem_wbe=1111, mem_d=0xDEADBEEF; N+1 rsp_valid=1, rsp_err=0.
REQ-037 Store byte 0xA5 @0x0013, then signed byte load @0x0013 -> mem_wbe=1000, mem_d=0xA5000000; load rsp_rdata=0xFFFFFFA5 at accept+2; unsigned load gives 0x000000A5.
REQ-038 MISALIGN_EN: words 4=0x44332211, 5=0x88776655; word load @0x0012 -> addresses 4 then 5, rsp_rdata=0x66554433 at N+3.
REQ-039 MISALIGN_EN: store word 0x11223344 @0xFFFF (AWIDTH=14) -> N: addr 0x3FFF wbe 1000 d 0x44000000; N+1: addr 0 wbe 0111 d 0x00112233; rsp at N+2.
REQ-040 Without macro: load half @0x0003 -> no mem_wen, rsp_err=1, rsp_rdata=0 at N+1; req_size=3 -> rsp_err=1 in both builds.
REQ-041 rst asserted in LD1 -> no rsp_valid, req_ready=1 the cycle after rst deasserts; rst in ST2 -> mem_wen=0, word W+1 unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM states and byte-mask table for the data-memory LSU
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_R = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD1  = 3'd1,
        LD2  = 3'd2,
        ST2  = 3'd3,
        RSP  = 3'd4
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // An access is misaligned only when its bytes spill into the next word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - load lane extraction across a word pair with sign/zero extension
module dmem_lsu_align
    import dmem_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [63:0] pair;
    logic [31:0] win;
    logic        sext;

    assign pair = {hi, lo};
    assign win  = pair[{off, 3'b000} +: 32];
    assign sext = ~is_unsigned;

    always_comb begin
        case (size)
            SZ_B:    data = {{24{sext & win[7]}}, win[7:0]};
            SZ_H:    data = {{16{sext & win[15]}}, win[15:0]};
            default: data = win;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit to a 32-bit RAM port; DMEM_LSU_MISALIGN_EN enables two-beat misaligned access
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    output logic              mem_wen,
    output logic [3:0]        mem_wbe,
    input  logic [DWIDTH-1:0] mem_q
);

    state_t            state, state_d;
    logic              accept, reject, mis;
    logic [1:0]        off;
    logic [AWIDTH-1:0] word_addr, st_addr;
    logic [1:0]        st_off, st_size;
    logic              st_uns;
    logic [31:0]       ld_lo, ld_hi, ld_data;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign word_addr = req_addr[AWIDTH+1:2];
    assign mis       = is_misaligned(req_size, off);

`ifdef DMEM_LSU_MISALIGN_EN
    logic [7:0]  lane_be;
    logic [63:0] lane_d;
    logic [3:0]  st_hi_be;
    logic [31:0] st_hi_d, lo_q;
    logic        st_mis;

    // Shifting across a 64-bit pair yields both beats: low half to W, high half to W+1.
    assign reject  = (req_size == SZ_R);
    assign lane_be = {4'b0000, size_mask(req_size)} << off;
    assign lane_d  = {32'd0, req_wdata} << {off, 3'b000};
    assign ld_lo   = (state == LD2) ? lo_q : mem_q;
    assign ld_hi   = mem_q;
`else
    logic [3:0]  lane_be;
    logic [31:0] lane_d;

    assign reject  = (req_size == SZ_R) || mis;
    assign lane_be = size_mask(req_size) << off;
    assign lane_d  = req_wdata << {off, 3'b000};
    assign ld_lo   = mem_q;
    assign ld_hi   = 32'd0;
`endif

    dmem_lsu_align u_align (
        .lo          (ld_lo),
        .hi          (ld_hi),
        .off         (st_off),
        .size        (st_size),
        .is_unsigned (st_uns),
        .data        (ld_data)
    );

    always_comb begin
        state_d  = state;
        mem_addr = st_addr;
        mem_d    = '0;
        mem_wen  = 1'b0;
        mem_wbe  = 4'b0000;
        case (state)
            IDLE: begin
                mem_addr = word_addr;
                if (accept && !reject) begin
                    if (req_we) begin
                        mem_wen = 1'b1;
                        mem_wbe = lane_be[3:0];
                        mem_d   = lane_d[31:0];
`ifdef DMEM_LSU_MISALIGN_EN
                        if (mis) state_d = ST2;
`endif
                    end else begin
                        state_d = LD1;
                    end
                end
            end
            LD1: begin
`ifdef DMEM_LSU_MISALIGN_EN
                state_d = st_mis ? LD2 : RSP;
`else
                state_d = RSP;
`endif
            end
`ifdef DMEM_LSU_MISALIGN_EN
            LD2: state_d = RSP;
            ST2: begin
                mem_wen = 1'b1;
                mem_wbe = st_hi_be;
                mem_d   = st_hi_d;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (rst) begin
            mem_wen = 1'b0;
            mem_wbe = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            st_addr   <= '0;
            st_off    <= 2'd0;
            st_size   <= 2'd0;
            st_uns    <= 1'b0;
`ifdef DMEM_LSU_MISALIGN_EN
            st_mis    <= 1'b0;
            st_hi_be  <= 4'b0000;
            st_hi_d   <= 32'd0;
            lo_q      <= 32'd0;
`endif
        end else begin
            state     <= state_d;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (accept) begin
                st_addr <= word_addr + {{(AWIDTH-1){1'b0}}, 1'b1};
                st_off  <= off;
                st_size <= req_size;
                st_uns  <= req_unsigned;
`ifdef DMEM_LSU_MISALIGN_EN
                st_mis   <= mis;
                st_hi_be <= lane_be[7:4];
                st_hi_d  <= lane_d[63:32];
`endif
                if (reject) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end else if (req_we && (state_d == IDLE)) begin
                    rsp_valid <= 1'b1;
                end
            end
`ifdef DMEM_LSU_MISALIGN_EN
            if (state == LD1) lo_q <= mem_q;
            if (state == ST2) rsp_valid <= 1'b1;
`endif
            if (state_d == RSP) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ld_data;
            end
        end
    end

endmodule
